// File: rtl/td4x_cpu.sv
// -----------------------------------------------------------------------------
// td4x_cpu -- a small accumulator-style CPU in the spirit of the TD4.
//
// Architectural state: A, B, OUT (DW bits), PC (AW bits), carry C and a
// two-state control FSM {RUN, HALT}. One instruction retires per clock while
// the core is running, enabled by `run` and not waiting on the input port.
//
// Instruction word: {op[3:0], imm[DW-1:0]}. Data operations compute
// src + imm in DW+1 bits; the low DW bits are the result and the top bit is
// the carry-out.
//
// Ports:
//   clock      single clock, all state changes on the rising edge
//   reset      synchronous, active-low reset (priority over everything)
//   run        execute enable; low freezes every architectural register
//   prog_addr  program memory address (always equal to PC)
//   prog_data  instruction fetched combinationally from prog_addr
//   in_data    input port value
//   in_valid   in_data is valid
//   in_ready   core consumes in_data this cycle (IN instruction executing)
//   out_data   output port register
//   out_valid  one-cycle pulse in the cycle after out_data was written
//   halted     core is in the HALT state
//   carry      carry flag C
// -----------------------------------------------------------------------------
module td4x_cpu #(
    parameter int DW = 4,
    parameter int AW = 4
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          run,
    output logic [AW-1:0] prog_addr,
    input  logic [DW+3:0] prog_data,
    input  logic [DW-1:0] in_data,
    input  logic          in_valid,
    output logic          in_ready,
    output logic [DW-1:0] out_data,
    output logic          out_valid,
    output logic          halted,
    output logic          carry
);

    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_HALT = 1'b1
    } state_e;

    typedef enum logic [3:0] {
        OP_ADD_A  = 4'b0000,  // A <= A + imm
        OP_MOV_AB = 4'b0001,  // A <= B + imm
        OP_IN_A   = 4'b0010,  // A <= in + imm
        OP_MOV_A  = 4'b0011,  // A <= imm
        OP_MOV_BA = 4'b0100,  // B <= A + imm
        OP_ADD_B  = 4'b0101,  // B <= B + imm
        OP_IN_B   = 4'b0110,  // B <= in + imm
        OP_MOV_B  = 4'b0111,  // B <= imm
        OP_HALT   = 4'b1000,
        OP_OUT_B  = 4'b1001,  // OUT <= B + imm
        OP_JC     = 4'b1010,
        OP_OUT_I  = 4'b1011,  // OUT <= imm
        OP_NOP0   = 4'b1100,
        OP_NOP1   = 4'b1101,
        OP_JNC    = 4'b1110,
        OP_JMP    = 4'b1111
    } op_e;

    // Architectural registers and their next-state values.
    state_e        state_q, state_d;
    logic [DW-1:0] a_q, a_d;
    logic [DW-1:0] b_q, b_d;
    logic [DW-1:0] out_q, out_d;
    logic [AW-1:0] pc_q, pc_d;
    logic          c_q, c_d;
    logic          out_valid_q, out_valid_d;

    // Decode / datapath signals.
    op_e           op;
    logic [DW-1:0] imm;
    logic          active;
    logic          stall;
    logic          exec;
    logic [DW-1:0] src;
    logic [DW:0]   sum;
    logic [DW-1:0] result;
    logic          cout;
    logic [AW-1:0] pc_inc;
    logic [AW-1:0] jump_target;

    assign op          = op_e'(prog_data[DW+3:DW]);
    assign imm         = prog_data[DW-1:0];
    assign jump_target = imm[AW-1:0];
    assign pc_inc      = pc_q + {{(AW-1){1'b0}}, 1'b1};

    // The core can do work only while running and not halted; `run` is
    // ignored in HALT because active stays low there.
    assign active   = (state_q == ST_RUN) && run;
    assign in_ready = active && ((op == OP_IN_A) || (op == OP_IN_B));
    assign stall    = in_ready && !in_valid;
    assign exec     = active && !stall;

    // Operand source for the shared adder. Immediate-only moves and jumps
    // add to zero, so their carry-out is always 0.
    always_comb begin
        src = '0;
        unique case (op)
            OP_ADD_A, OP_MOV_BA: src = a_q;
            OP_MOV_AB, OP_ADD_B,
            OP_OUT_B:            src = b_q;
            OP_IN_A, OP_IN_B:    src = in_data;
            default:             src = '0;
        endcase
    end

    assign sum    = {1'b0, src} + {1'b0, imm};
    assign result = sum[DW-1:0];
    assign cout   = sum[DW];

    // Next-state logic. Every register holds unless an instruction executes.
    // NOTE: every signal written here gets a default first; a path that left
    // one unassigned would infer a latch instead of combinational logic.
    always_comb begin
        state_d     = state_q;
        a_d         = a_q;
        b_d         = b_q;
        out_d       = out_q;
        pc_d        = pc_q;
        c_d         = c_q;
        out_valid_d = 1'b0;

        if (exec) begin
            pc_d = pc_inc;
            unique case (op)
                OP_ADD_A, OP_MOV_AB, OP_IN_A, OP_MOV_A: begin
                    a_d = result;
                    c_d = cout;
                end
                OP_MOV_BA, OP_ADD_B, OP_IN_B, OP_MOV_B: begin
                    b_d = result;
                    c_d = cout;
                end
                OP_OUT_B, OP_OUT_I: begin
                    out_d       = result;
                    c_d         = cout;
                    out_valid_d = 1'b1;
                end
                OP_HALT: begin
                    // PC stays on the HALT instruction.
                    pc_d    = pc_q;
                    state_d = ST_HALT;
                end
                // Branches test the carry from before this instruction and
                // leave it untouched, so JNC/JC pairs see the same flag.
                OP_JNC: pc_d = c_q ? pc_inc : jump_target;
                OP_JC:  pc_d = c_q ? jump_target : pc_inc;
                OP_JMP: pc_d = jump_target;
                OP_NOP0, OP_NOP1: ;
                default: ;
            endcase
        end
    end

    // State register. Reset is synchronous and wins over run, stall and
    // instruction execution.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples its next value from the same pre-edge snapshot.
    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q     <= ST_RUN;
            a_q         <= '0;
            b_q         <= '0;
            out_q       <= '0;
            pc_q        <= '0;
            c_q         <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            a_q         <= a_d;
            b_q         <= b_d;
            out_q       <= out_d;
            pc_q        <= pc_d;
            c_q         <= c_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign prog_addr = pc_q;
    assign out_data  = out_q;
    assign out_valid = out_valid_q;
    assign halted    = (state_q == ST_HALT);
    assign carry     = c_q;

endmodule

// File: tb/tb_td4x_cpu.sv
// -----------------------------------------------------------------------------
// tb_td4x_cpu -- self-checking bench for td4x_cpu.
// A DW=4/AW=4 core runs a table of instruction vectors, hand-written corner
// sequences (input stall, output pulse, halt, reset) and a randomized run
// against a behavioural model. A DW=8/AW=6 core checks the wide-datapath case.
// -----------------------------------------------------------------------------
module tb_td4x_cpu;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic       run = 1'b0;
    logic       in_valid = 1'b0;
    logic [3:0] in_data = 4'h0;
    logic [3:0] prog_addr;
    logic [7:0] prog_data;
    logic       in_ready;
    logic [3:0] out_data;
    logic       out_valid;
    logic       halted;
    logic       carry;
    logic [7:0] rom [16];

    // Wide instance: DW=8, AW=6.
    logic        run2 = 1'b0;
    logic [5:0]  prog_addr2;
    logic [11:0] prog_data2;
    logic        in_ready2;
    logic [7:0]  out_data2;
    logic        out_valid2;
    logic        halted2;
    logic        carry2;
    logic [11:0] rom2 [64];

    int total = 0;
    int bad   = 0;

    always #5 clock = ~clock;

    assign prog_data  = rom[prog_addr];
    assign prog_data2 = rom2[prog_addr2];

    td4x_cpu #(.DW(4), .AW(4)) dut (
        .clock     (clock),
        .reset     (reset),
        .run       (run),
        .prog_addr (prog_addr),
        .prog_data (prog_data),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_valid (out_valid),
        .halted    (halted),
        .carry     (carry)
    );

    td4x_cpu #(.DW(8), .AW(6)) dut2 (
        .clock     (clock),
        .reset     (reset),
        .run       (run2),
        .prog_addr (prog_addr2),
        .prog_data (prog_data2),
        .in_data   (8'h00),
        .in_valid  (1'b0),
        .in_ready  (in_ready2),
        .out_data  (out_data2),
        .out_valid (out_valid2),
        .halted    (halted2),
        .carry     (carry2)
    );

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Advance one clock; outputs are sampled 1 time unit after the edge.
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        tick();
        reset = 1'b1;
    endtask

    task automatic fill_nop();
        for (int i = 0; i < 16; i++) rom[i] = 8'hC0;
    endtask

    // ---------------- table-driven vectors ----------------
    typedef struct {
        logic [3:0] addr;
        logic [7:0] instr;
        logic [3:0] in_d;
        logic [3:0] a;
        logic [3:0] b;
        logic [3:0] o;
        logic       c;
        logic [3:0] pc;
        logic       ov;
    } vec_t;

    vec_t vecs[15];

    // ---------------- behavioural reference model ----------------
    int m_pc, m_a, m_b, m_o, m_c, m_h, m_ov;

    function automatic int wrap16(input int v);
        return v % 16;
    endfunction

    // Computes the architectural effect of one clock edge from the ISA rules.
    task automatic model_edge(input int rst_n, input int run_v, input int iv, input int id);
        int instr, op, imm, s;
        instr = int'(rom[m_pc]);
        op    = instr / 16;
        imm   = instr % 16;
        if (rst_n == 0) begin
            m_pc = 0; m_a = 0; m_b = 0; m_o = 0; m_c = 0; m_h = 0; m_ov = 0;
        end else begin
            m_ov = 0;
            if (m_h == 0 && run_v != 0 && !((op == 2 || op == 6) && iv == 0)) begin
                case (op)
                    0:  begin s = m_a + imm; m_a = wrap16(s); m_c = s / 16; end
                    1:  begin s = m_b + imm; m_a = wrap16(s); m_c = s / 16; end
                    2:  begin s = id + imm;  m_a = wrap16(s); m_c = s / 16; end
                    3:  begin m_a = imm; m_c = 0; end
                    4:  begin s = m_a + imm; m_b = wrap16(s); m_c = s / 16; end
                    5:  begin s = m_b + imm; m_b = wrap16(s); m_c = s / 16; end
                    6:  begin s = id + imm;  m_b = wrap16(s); m_c = s / 16; end
                    7:  begin m_b = imm; m_c = 0; end
                    9:  begin s = m_b + imm; m_o = wrap16(s); m_c = s / 16; m_ov = 1; end
                    11: begin m_o = imm; m_c = 0; m_ov = 1; end
                    default: ;
                endcase
                if (op == 8)                    m_h = 1;
                else if (op == 15)              m_pc = imm;
                else if (op == 14 && m_c_before(instr) == 0) m_pc = imm;
                else if (op == 10 && m_c_before(instr) == 1) m_pc = imm;
                else                            m_pc = wrap16(m_pc + 1);
            end
        end
    endtask

    // Branches never modify C, so the flag after the data step equals the
    // flag before the instruction for every branch opcode.
    function automatic int m_c_before(input int instr);
        return (instr >= 0) ? m_c : 0;
    endfunction

    initial begin
        int exp_rdy, r_rst, r_run, r_iv, r_id, instr;

        // ---------------- reset state ----------------
        fill_nop();
        for (int i = 0; i < 64; i++) rom2[i] = 12'hC00;
        reset = 1'b0;
        tick();
        check("reset_pc", int'(prog_addr), 0);
        check("reset_a", int'(dut.a_q), 0);
        check("reset_b", int'(dut.b_q), 0);
        check("reset_out", int'(out_data), 0);
        check("reset_carry", int'(carry), 0);
        check("reset_halted", int'(halted), 0);
        check("reset_out_valid", int'(out_valid), 0);

        // ---------------- vector table ----------------
        //            addr  instr   in    A     B     OUT   C     PC    ov
        vecs[0]  = '{4'd0,  8'h3F, 4'h0, 4'hF, 4'h0, 4'h0, 1'b0, 4'd1,  1'b0};
        vecs[1]  = '{4'd1,  8'h01, 4'h0, 4'h0, 4'h0, 4'h0, 1'b1, 4'd2,  1'b0};
        vecs[2]  = '{4'd2,  8'hE7, 4'h0, 4'h0, 4'h0, 4'h0, 1'b1, 4'd3,  1'b0};
        vecs[3]  = '{4'd3,  8'hA5, 4'h0, 4'h0, 4'h0, 4'h0, 1'b1, 4'd5,  1'b0};
        vecs[4]  = '{4'd5,  8'h43, 4'h0, 4'h0, 4'h3, 4'h0, 1'b0, 4'd6,  1'b0};
        vecs[5]  = '{4'd6,  8'h5E, 4'h0, 4'h0, 4'h1, 4'h0, 1'b1, 4'd7,  1'b0};
        vecs[6]  = '{4'd7,  8'h92, 4'h0, 4'h0, 4'h1, 4'h3, 1'b0, 4'd8,  1'b1};
        vecs[7]  = '{4'd8,  8'h25, 4'hC, 4'h1, 4'h1, 4'h3, 1'b1, 4'd9,  1'b0};
        vecs[8]  = '{4'd9,  8'h19, 4'h0, 4'hA, 4'h1, 4'h3, 1'b0, 4'd10, 1'b0};
        vecs[9]  = '{4'd10, 8'h60, 4'h7, 4'hA, 4'h7, 4'h3, 1'b0, 4'd11, 1'b0};
        vecs[10] = '{4'd11, 8'hC0, 4'h0, 4'hA, 4'h7, 4'h3, 1'b0, 4'd12, 1'b0};
        vecs[11] = '{4'd12, 8'h7F, 4'h0, 4'hA, 4'hF, 4'h3, 1'b0, 4'd13, 1'b0};
        vecs[12] = '{4'd13, 8'hBA, 4'h0, 4'hA, 4'hF, 4'hA, 1'b0, 4'd14, 1'b1};
        vecs[13] = '{4'd14, 8'hFF, 4'h0, 4'hA, 4'hF, 4'hA, 1'b0, 4'd15, 1'b0};
        vecs[14] = '{4'd15, 8'hD0, 4'h0, 4'hA, 4'hF, 4'hA, 1'b0, 4'd0,  1'b0};
        foreach (vecs[i]) rom[vecs[i].addr] = vecs[i].instr;
        reset    = 1'b1;
        run      = 1'b1;
        in_valid = 1'b1;
        foreach (vecs[i]) begin
            in_data = vecs[i].in_d;
            #1;
            check($sformatf("vec%0d_fetch_addr", i), int'(prog_addr), int'(vecs[i].addr));
            tick();
            check($sformatf("vec%0d_a", i), int'(dut.a_q), int'(vecs[i].a));
            check($sformatf("vec%0d_b", i), int'(dut.b_q), int'(vecs[i].b));
            check($sformatf("vec%0d_out", i), int'(out_data), int'(vecs[i].o));
            check($sformatf("vec%0d_carry", i), int'(carry), int'(vecs[i].c));
            check($sformatf("vec%0d_pc", i), int'(prog_addr), int'(vecs[i].pc));
            check($sformatf("vec%0d_out_valid", i), int'(out_valid), int'(vecs[i].ov));
        end

        // ---------------- input stall ----------------
        fill_nop();
        rom[0] = 8'h3F;  // MOV A,F
        rom[1] = 8'h01;  // ADD A,1 -> C=1
        rom[2] = 8'h20;  // IN A,0
        do_reset();
        run = 1'b1;
        in_valid = 1'b1;
        tick();
        tick();
        check("stall_pre_carry", int'(carry), 1);
        in_valid = 1'b0;
        in_data  = 4'h3;
        for (int i = 0; i < 3; i++) begin
            #1;
            check($sformatf("stall%0d_in_ready", i), int'(in_ready), 1);
            tick();
            check($sformatf("stall%0d_pc", i), int'(prog_addr), 2);
            check($sformatf("stall%0d_a", i), int'(dut.a_q), 0);
            check($sformatf("stall%0d_carry", i), int'(carry), 1);
        end
        run = 1'b0;
        #1;
        check("stall_run0_in_ready", int'(in_ready), 0);
        tick();
        check("stall_run0_pc", int'(prog_addr), 2);
        run      = 1'b1;
        in_valid = 1'b1;
        in_data  = 4'h9;
        #1;
        check("stall_release_in_ready", int'(in_ready), 1);
        tick();
        check("stall_release_a", int'(dut.a_q), 9);
        check("stall_release_pc", int'(prog_addr), 3);
        check("stall_release_carry", int'(carry), 0);

        // ---------------- output pulse and run=0 freeze ----------------
        fill_nop();
        rom[0] = 8'hBA;  // OUT A
        do_reset();
        run = 1'b1;
        tick();
        check("out_data", int'(out_data), 4'hA);
        check("out_valid_pulse", int'(out_valid), 1);
        check("out_pc", int'(prog_addr), 1);
        run = 1'b0;
        for (int i = 0; i < 2; i++) begin
            tick();
            check($sformatf("out_freeze%0d_valid", i), int'(out_valid), 0);
            check($sformatf("out_freeze%0d_data", i), int'(out_data), 4'hA);
            check($sformatf("out_freeze%0d_pc", i), int'(prog_addr), 1);
        end

        // ---------------- halt, then reset out of HALT ----------------
        fill_nop();
        rom[0] = 8'hBA;  // OUT A
        rom[1] = 8'h3B;  // MOV A,B
        rom[2] = 8'h0A;  // ADD A,A -> A=5, C=1
        rom[3] = 8'h80;  // HALT
        do_reset();
        run = 1'b1;
        for (int i = 0; i < 4; i++) tick();
        check("halt_halted", int'(halted), 1);
        check("halt_pc", int'(prog_addr), 3);
        check("halt_a", int'(dut.a_q), 5);
        check("halt_carry", int'(carry), 1);
        for (int i = 0; i < 10; i++) begin
            tick();
            check($sformatf("halt_hold%0d_pc", i), int'(prog_addr), 3);
            check($sformatf("halt_hold%0d_halted", i), int'(halted), 1);
        end
        rom[3] = 8'h20;  // an IN opcode at PC must not raise in_ready in HALT
        #1;
        check("halt_in_ready", int'(in_ready), 0);
        rom[3] = 8'h80;
        reset = 1'b0;
        tick();
        reset = 1'b1;
        check("halt_reset_pc", int'(prog_addr), 0);
        check("halt_reset_a", int'(dut.a_q), 0);
        check("halt_reset_b", int'(dut.b_q), 0);
        check("halt_reset_out", int'(out_data), 0);
        check("halt_reset_carry", int'(carry), 0);
        check("halt_reset_halted", int'(halted), 0);

        // ---------------- wide core DW=8, AW=6 ----------------
        run = 1'b0;
        rom2[0] = 12'h3FF;  // MOV A,FF
        rom2[1] = 12'h001;  // ADD A,01
        rom2[2] = 12'hF2A;  // JMP 2A
        do_reset();
        run2 = 1'b1;
        tick();
        check("wide_mov_a", int'(dut2.a_q), 8'hFF);
        tick();
        check("wide_add_a", int'(dut2.a_q), 0);
        check("wide_add_carry", int'(carry2), 1);
        tick();
        check("wide_jmp_addr", int'(prog_addr2), 6'h2A);
        run2 = 1'b0;

        // ---------------- randomized run against the model ----------------
        for (int i = 0; i < 16; i++) begin
            instr = int'($urandom_range(0, 255));
            // Keep HALT rare so most of the run exercises live execution.
            if (instr / 16 == 8 && $urandom_range(0, 3) != 0) instr = instr + 16;
            rom[i] = 8'(instr);
        end
        do_reset();
        m_pc = 0; m_a = 0; m_b = 0; m_o = 0; m_c = 0; m_h = 0; m_ov = 0;
        for (int cyc = 0; cyc < 600; cyc++) begin
            r_rst = ($urandom_range(0, 79) != 0) ? 1 : 0;
            r_run = ($urandom_range(0, 5) != 0) ? 1 : 0;
            r_iv  = ($urandom_range(0, 2) != 0) ? 1 : 0;
            r_id  = int'($urandom_range(0, 15));
            reset    = r_rst[0];
            run      = r_run[0];
            in_valid = r_iv[0];
            in_data  = 4'(r_id);
            #1;
            instr   = int'(rom[m_pc]);
            exp_rdy = (m_h == 0 && r_run != 0 && (instr / 16 == 2 || instr / 16 == 6)) ? 1 : 0;
            check($sformatf("rnd%0d_in_ready", cyc), int'(in_ready), exp_rdy);
            model_edge(r_rst, r_run, r_iv, r_id);
            tick();
            check($sformatf("rnd%0d_pc", cyc), int'(prog_addr), m_pc);
            check($sformatf("rnd%0d_a", cyc), int'(dut.a_q), m_a);
            check($sformatf("rnd%0d_b", cyc), int'(dut.b_q), m_b);
            check($sformatf("rnd%0d_out", cyc), int'(out_data), m_o);
            check($sformatf("rnd%0d_carry", cyc), int'(carry), m_c);
            check($sformatf("rnd%0d_halted", cyc), int'(halted), m_h);
            check($sformatf("rnd%0d_out_valid", cyc), int'(out_valid), m_ov);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
